// File: rtl/quad_pkg.sv
// Shared types and Gray-code step helpers for the quadrature decoder.
// QUAD_DEBOUNCE_EN selects whether the per-phase debounce filter is built.
package quad_pkg;

   typedef enum logic {
      INIT,
      TRACK
   } dec_state_t;

   typedef enum logic [1:0] {
      IDLE,
      RIGHT,
      LEFT
   } str_state_t;

   function automatic bit debounce_en();
`ifdef QUAD_DEBOUNCE_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   // Forward (clockwise) order: 00 -> 01 -> 11 -> 10 -> 00
   function automatic logic fwd(input logic [1:0] prev, input logic [1:0] cur);
      logic res;
      unique case (prev)
         2'b00:   res = (cur == 2'b01);
         2'b01:   res = (cur == 2'b11);
         2'b11:   res = (cur == 2'b10);
         default: res = (cur == 2'b00);
      endcase
      return res;
   endfunction

   function automatic logic rev(input logic [1:0] prev, input logic [1:0] cur);
      logic res;
      unique case (prev)
         2'b00:   res = (cur == 2'b10);
         2'b10:   res = (cur == 2'b11);
         2'b11:   res = (cur == 2'b01);
         default: res = (cur == 2'b00);
      endcase
      return res;
   endfunction

endpackage

// File: rtl/quad_filter.sv
// One encoder phase: 2-flop synchronizer followed by an optional debounce filter.
// FILTER_LEN is 0 when QUAD_DEBOUNCE_EN is undefined, which bypasses the filter.
module quad_filter
   import quad_pkg::*;
#(
   parameter int unsigned FILTER_LEN = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic s1_q, s2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= din;
         s2_q <= s1_q;
      end
   end

   if (FILTER_LEN > 0) begin : g_debounce
      localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

      logic [CntW-1:0] cnt_q, cnt_d;
      logic            filt_q, filt_d;

      // Counts consecutive cycles the input disagrees with the accepted value
      always_comb begin
         cnt_d  = '0;
         filt_d = filt_q;
         if (s2_q != filt_q) begin
            if (cnt_q == CntW'(FILTER_LEN - 1)) begin
               filt_d = s2_q;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
         end
      end

      assign dout = filt_q;
   end else begin : g_bypass
      assign dout = s2_q;
   end

endmodule

// File: rtl/quad_decoder.sv
// 4x quadrature decoder: phase tracking, wrapping signed position and stretched left/right levels.
// Build with QUAD_DEBOUNCE_EN defined to insert the FILTER_LEN debounce filter on both phases.
module quad_decoder
   import quad_pkg::*;
#(
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned HOLD       = 22500,
   parameter int unsigned FILTER_LEN = 4
) (
   input  logic                    CLK,
   input  logic                    Reset_n,
   input  logic                    clr,
   input  logic                    quad_a,
   input  logic                    quad_b,
   output logic signed [CNT_W-1:0] position,
   output logic                    step,
   output logic                    dir,
   output logic                    right,
   output logic                    left,
   output logic                    err
);

   localparam int unsigned FLEN     = debounce_en() ? FILTER_LEN : 0;
   localparam int unsigned INIT_LEN = 3 + FLEN;
   localparam int unsigned INIT_W   = $clog2(INIT_LEN);
   localparam int unsigned HOLD_W   = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

   logic       a_f, b_f;
   logic [1:0] ph, ph_q;

   quad_filter #(
      .FILTER_LEN(FLEN)
   ) u_filt_a (
      .clk  (CLK),
      .rst_n(Reset_n),
      .din  (quad_a),
      .dout (a_f)
   );

   quad_filter #(
      .FILTER_LEN(FLEN)
   ) u_filt_b (
      .clk  (CLK),
      .rst_n(Reset_n),
      .din  (quad_b),
      .dout (b_f)
   );

   assign ph = {a_f, b_f};

   // ---------------- decoder FSM ----------------
   dec_state_t        dec_q, dec_d;
   logic [INIT_W-1:0] init_q, init_d;
   logic [1:0]        prev_q, prev_d;
   logic              fwd_ev, rev_ev, ill_ev;

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         dec_q  <= INIT;
         init_q <= '0;
         prev_q <= 2'b00;
         ph_q   <= 2'b00;
      end else begin
         dec_q  <= dec_d;
         init_q <= init_d;
         prev_q <= prev_d;
         ph_q   <= ph;
      end
   end

   // prev is loaded from ph (one stage ahead of ph_q) so it matches ph_q on the first TRACK cycle
   always_comb begin
      dec_d  = dec_q;
      init_d = init_q;
      prev_d = prev_q;
      unique case (dec_q)
         INIT: begin
            init_d = init_q + INIT_W'(1);
            if (init_q == INIT_W'(INIT_LEN - 1)) begin
               dec_d  = TRACK;
               init_d = '0;
               prev_d = ph;
            end
         end
         TRACK: begin
            if (ph_q != prev_q) begin
               prev_d = ph_q;
            end
         end
         default: dec_d = INIT;
      endcase
   end

   always_comb begin
      fwd_ev = 1'b0;
      rev_ev = 1'b0;
      ill_ev = 1'b0;
      if (dec_q == TRACK) begin
         fwd_ev = fwd(prev_q, ph_q);
         rev_ev = rev(prev_q, ph_q);
         ill_ev = ((prev_q ^ ph_q) == 2'b11);
      end
   end

   // ---------------- position / status ----------------
   logic signed [CNT_W-1:0] pos_q, pos_d;
   logic                    step_q, dir_q, err_q;

   always_comb begin
      pos_d = pos_q;
      if (clr) begin
         pos_d = '0;
      end else if (fwd_ev) begin
         pos_d = pos_q + CNT_W'(1);
      end else if (rev_ev) begin
         pos_d = pos_q - CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         pos_q  <= '0;
         step_q <= 1'b0;
         dir_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         pos_q  <= pos_d;
         step_q <= fwd_ev | rev_ev;
         if (fwd_ev | rev_ev) begin
            dir_q <= fwd_ev;
         end
         if (clr) begin
            err_q <= 1'b0;
         end else if (ill_ev) begin
            err_q <= 1'b1;
         end
      end
   end

   assign position = pos_q;
   assign step     = step_q;
   assign dir      = dir_q;
   assign err      = err_q;

   // ---------------- stretch FSM ----------------
   str_state_t        str_q, str_d;
   logic [HOLD_W-1:0] hold_q, hold_d;

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         str_q  <= IDLE;
         hold_q <= '0;
      end else begin
         str_q  <= str_d;
         hold_q <= hold_d;
      end
   end

   always_comb begin
      str_d  = str_q;
      hold_d = hold_q;
      if (fwd_ev) begin
         str_d  = RIGHT;
         hold_d = HOLD_W'(HOLD);
      end else if (rev_ev) begin
         str_d  = LEFT;
         hold_d = HOLD_W'(HOLD);
      end else begin
         unique case (str_q)
            RIGHT, LEFT: begin
               if (hold_q == '0) begin
                  str_d = IDLE;
               end else begin
                  hold_d = hold_q - HOLD_W'(1);
               end
            end
            default: str_d = IDLE;
         endcase
      end
   end

   always_comb begin
      right = (str_q == RIGHT);
      left  = (str_q == LEFT);
   end

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder (CNT_W=8, HOLD=20, FILTER_LEN=4).
// Works in both builds; the glitch test is only run with QUAD_DEBOUNCE_EN defined.
module tb_quad_decoder;

`ifdef QUAD_DEBOUNCE_EN
   localparam int LAT = 7;
   localparam int GAP = 6;
`else
   localparam int LAT = 3;
   localparam int GAP = 2;
`endif

   typedef struct {
      logic dir;
      int   pos;
   } exp_t;

   typedef struct packed {
      logic [1:0] ab;
      bit         is_step;
      logic       dir;
      int         pos;
      logic       err;
      logic       r;
      logic       l;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              clr = 1'b0;
   logic [1:0]        ab = 2'b00;
   logic signed [7:0] position;
   logic              step, dir, right, left, err;

   int   total = 0;
   int   bad = 0;
   int   model_pos = 0;
   exp_t sbq[$];
   exp_t mon_e;
   vec_t tbl[9];

   always #5 clk = ~clk;

   quad_decoder #(
      .CNT_W     (8),
      .HOLD      (20),
      .FILTER_LEN(4)
   ) dut (
      .CLK     (clk),
      .Reset_n (rst_n),
      .clr     (clr),
      .quad_a  (ab[1]),
      .quad_b  (ab[0]),
      .position(position),
      .step    (step),
      .dir     (dir),
      .right   (right),
      .left    (left),
      .err     (err)
   );

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   function automatic logic [1:0] fwd_of(input logic [1:0] x);
      case (x)
         2'b00:   return 2'b01;
         2'b01:   return 2'b11;
         2'b11:   return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [1:0] rev_of(input logic [1:0] x);
      case (x)
         2'b00:   return 2'b10;
         2'b10:   return 2'b11;
         2'b11:   return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   function automatic int wrap8(input int v);
      logic signed [7:0] t;
      t = v[7:0];
      return int'(t);
   endfunction

   task automatic drive_step(input logic d);
      @(negedge clk);
      ab = d ? fwd_of(ab) : rev_of(ab);
      model_pos = wrap8(model_pos + (d ? 1 : -1));
      sbq.push_back('{dir: d, pos: model_pos});
   endtask

   // Scoreboard consumer: every step pulse must match the oldest expected step
   always @(negedge clk) begin
      if (rst_n && step) begin
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_step: got step=1 required step=0 at %0t", $time);
         end else begin
            mon_e = sbq.pop_front();
            check("step_dir", dir, mon_e.dir);
            check("step_pos", $signed(position), mon_e.pos);
            check("step_right", right, mon_e.dir);
            check("step_left", left, !mon_e.dir);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish before 500000");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int hc;

      tbl[0] = '{2'b01, 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0};
      tbl[1] = '{2'b11, 1'b1, 1'b1, 2, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{2'b10, 1'b1, 1'b1, 3, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{2'b00, 1'b1, 1'b1, 4, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{2'b10, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b1};
      tbl[5] = '{2'b11, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b1};
      tbl[6] = '{2'b10, 1'b1, 1'b1, 3, 1'b0, 1'b1, 1'b0};
      tbl[7] = '{2'b00, 1'b1, 1'b1, 4, 1'b0, 1'b1, 1'b0};
      tbl[8] = '{2'b11, 1'b0, 1'b1, 4, 1'b1, 1'b1, 1'b0};

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_pos", $signed(position), 0);
      check("rst_step", step, 0);
      check("rst_dir", dir, 0);
      check("rst_right", right, 0);
      check("rst_left", left, 0);
      check("rst_err", err, 0);
      rst_n = 1'b1;
      repeat (LAT + 10) @(negedge clk);
      check("init_err", err, 0);
      check("init_pos", $signed(position), 0);

      // Table: forward, reverse, illegal
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         ab = tbl[i].ab;
         if (tbl[i].is_step) begin
            model_pos = tbl[i].pos;
            sbq.push_back('{dir: tbl[i].dir, pos: tbl[i].pos});
         end
         repeat (10) @(negedge clk);
         check($sformatf("vec%0d_pos", i), $signed(position), tbl[i].pos);
         check($sformatf("vec%0d_err", i), err, tbl[i].err);
         check($sformatf("vec%0d_right", i), right, tbl[i].r);
         check($sformatf("vec%0d_left", i), left, tbl[i].l);
      end

      // clr clears err and position
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      model_pos = 0;
      @(negedge clk);
      check("clr_err", err, 0);
      check("clr_pos", $signed(position), 0);

      // Wrap-around: 128 forward steps then one reverse
      repeat (128) begin
         drive_step(1'b1);
         repeat (GAP - 1) @(negedge clk);
      end
      repeat (LAT + 2) @(negedge clk);
      check("wrap_fwd_pos", $signed(position), -128);
      drive_step(1'b0);
      repeat (LAT + 2) @(negedge clk);
      check("wrap_rev_pos", $signed(position), 127);

      // Hold expiry and step latency
      repeat (40) @(negedge clk);
      check("idle_right", right, 0);
      check("idle_left", left, 0);
      @(negedge clk);
      ab = fwd_of(ab);
      model_pos = wrap8(model_pos + 1);
      sbq.push_back('{dir: 1'b1, pos: model_pos});
      lat = 0;
      forever begin
         @(negedge clk);
         if (step || lat >= 50) break;
         lat++;
      end
      check("step_latency", lat, LAT);
      hc = 0;
      while (right && hc < 100) begin
         hc++;
         @(negedge clk);
      end
      check("right_hold_cycles", hc, 21);
      check("hold_end_left", left, 0);

      // clr coinciding with the step cycle
      @(negedge clk);
      ab = fwd_of(ab);
      sbq.push_back('{dir: 1'b1, pos: 0});
      repeat (LAT) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      model_pos = 0;
      check("clr_step_pulse", step, 1);
      check("clr_step_pos", $signed(position), 0);

`ifdef QUAD_DEBOUNCE_EN
      // 3-cycle glitch on A is discarded
      repeat (30) @(negedge clk);
      @(negedge clk);
      ab[1] = ~ab[1];
      repeat (3) @(negedge clk);
      ab[1] = ~ab[1];
      repeat (20) @(negedge clk);
      check("glitch_pos", $signed(position), 0);
      check("glitch_err", err, 0);
`endif

      // Mid-operation reset with the inputs moving across it
      drive_step(1'b0);
      repeat (LAT + 2) @(negedge clk);
      check("pre_reset_pos", $signed(position), -1);
      rst_n = 1'b0;
      ab = ab ^ 2'b11;
      @(negedge clk);
      check("midrst_pos", $signed(position), 0);
      check("midrst_left", left, 0);
      model_pos = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (LAT + 20) @(negedge clk);
      check("post_reset_err", err, 0);
      check("post_reset_pos", $signed(position), 0);
      check("post_reset_dir", dir, 0);

      check("sb_drain", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
